sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer.sv | 146 ++++++++++++++
 tb/tb_sample_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// sample_framer: packs 48-bit FIFO samples into framed Ethernet bursts.
// Optional idle timeout closing partial frames: SAMPLE_FRAMER_TIMEOUT_EN.
module sample_framer #(
  parameter int          FRAME_SAMPLES  = 32,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] MAGIC          = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  output logic        fifo_read_enabled,
  input  logic [47:0] fifo_data_out,
  input  logic        fifo_data_out_valid,
  input  logic        eth_available,
  output logic [47:0] eth_data,
  output logic        eth_data_valid,
  output logic        eth_flush,
  output logic [15:0] frame_count
);

  if (FRAME_SAMPLES < 1 || FRAME_SAMPLES > 63 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_param
    $error("sample_framer: parameter out of range");
  end

  localparam logic [5:0] FS = 6'(FRAME_SAMPLES);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, HOLD, TRAILER, FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        armed;
  logic        gap;
  logic [47:0] hold;
  logic [47:0] last;
  logic [5:0]  count;
  logic [15:0] seq;
  logic        push;
  logic        flush_go;
  logic [47:0] push_word;
  logic        timeout;

`ifdef SAMPLE_FRAMER_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] timer;
  logic        idle_wait;

  assign idle_wait = (state == IDLE) && fifo_empty && (count != 6'd0);
  assign timeout   = idle_wait && (timer == TMO_LAST);

  // count idle clocks while a partial frame is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (idle_wait && !timeout) begin
      timer <= timer + 20'd1;
    end else begin
      timer <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, pop request and push/flush qualification
  always_comb begin
    state_nxt         = state;
    fifo_read_enabled = 1'b0;
    push              = 1'b0;
    flush_go          = 1'b0;
    push_word         = hold;
    unique case (state)
      IDLE: begin
        if (timeout) begin
          state_nxt = TRAILER;
        end else if (armed && !fifo_empty) begin
          fifo_read_enabled = 1'b1;
          state_nxt         = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (fifo_data_out_valid) state_nxt = HOLD;
      end
      HOLD: begin
        if (eth_available && !gap) begin
          push      = 1'b1;
          state_nxt = (count + 6'd1 == FS) ? TRAILER : IDLE;
        end
      end
      TRAILER: begin
        push_word = {MAGIC, seq, 2'b00, count, 8'h00};
        if (eth_available && !gap) begin
          push      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (eth_available && !gap) begin
          flush_go  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: held word, last push, counters, pulse spacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      gap   <= 1'b0;
      hold  <= '0;
      last  <= '0;
      count <= '0;
      seq   <= '0;
    end else begin
      armed <= 1'b1;
      gap   <= push | flush_go;
      if (state == WAIT_DATA && fifo_data_out_valid) hold <= fifo_data_out;
      if (push) last <= push_word;
      if (push && state == HOLD) count <= count + 6'd1;
      if (flush_go) begin
        count <= '0;
        seq   <= seq + 16'd1;
      end
    end
  end

  assign eth_data_valid = push;
  assign eth_flush      = flush_go;
  assign eth_data       = push ? push_word : last;
  assign frame_count    = seq;

endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed bench for sample_framer (FRAME_SAMPLES=4).
// Timeout case follows SAMPLE_FRAMER_TIMEOUT_EN when defined.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_read_enabled;
  logic [47:0] fifo_data_out = '0;
  logic        fifo_data_out_valid = 1'b0;
  logic        eth_available = 1'b0;
  logic [47:0] eth_data;
  logic        eth_data_valid;
  logic        eth_flush;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [47:0] fq[$];
  logic [48:0] outq[$];
  int          outt[$];
  logic [48:0] expq[$];
  logic        prev_pulse = 1'b0;
  logic [47:0] last_push = '0;
  logic        tog_stop = 1'b0;

  sample_framer #(
    .FRAME_SAMPLES (4),
    .TIMEOUT_CYCLES(100),
    .MAGIC         (16'hA5C3)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_empty         (fifo_empty),
    .fifo_read_enabled  (fifo_read_enabled),
    .fifo_data_out      (fifo_data_out),
    .fifo_data_out_valid(fifo_data_out_valid),
    .eth_available      (eth_available),
    .eth_data           (eth_data),
    .eth_data_valid     (eth_data_valid),
    .eth_flush          (eth_flush),
    .frame_count        (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: pop on request, data one cycle later
  always @(posedge clk) begin
    cyc++;
    if (fifo_read_enabled) begin
      chk("pop_nonempty", 64'(fq.size() > 0), 64'd1);
      if (fq.size() > 0) fifo_data_out <= fq.pop_front();
      fifo_data_out_valid <= 1'b1;
    end else begin
      fifo_data_out_valid <= 1'b0;
    end
  end

  always @(negedge clk) fifo_empty = (fq.size() == 0);

  // output monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 1'b0;
      last_push  = '0;
    end else begin
      if (eth_data_valid || eth_flush) begin
        chk("excl", 64'(eth_data_valid && eth_flush), 64'd0);
        chk("qual", 64'(eth_available), 64'd1);
        chk("gap", 64'(prev_pulse), 64'd0);
      end
      if (eth_data_valid) begin
        outq.push_back({1'b0, eth_data});
        outt.push_back(cyc);
        last_push = eth_data;
      end else begin
        chk("hold_data", 64'(eth_data), 64'(last_push));
      end
      if (eth_flush) begin
        outq.push_back({1'b1, 48'h0});
        outt.push_back(cyc);
      end
      prev_pulse = eth_data_valid | eth_flush;
    end
  end

  task automatic push_words(input logic [47:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 48'(i));
  endtask

  task automatic add_frame(input logic [47:0] base, input int n,
                           input logic [15:0] s);
    for (int i = 0; i < n; i++) expq.push_back({1'b0, base + 48'(i)});
    expq.push_back({1'b0, 16'hA5C3, s, 2'b00, 6'(n), 8'h00});
    expq.push_back({1'b1, 48'h0});
  endtask

  task automatic wait_out(input int n, input int lim, input string tag);
    int c = 0;
    while (outq.size() < n && c < lim) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    chk(tag, 64'(outq.size()), 64'(n));
  endtask

  task automatic cmp_all(input string tag);
    for (int i = 0; i < expq.size(); i++) begin
      if (i < outq.size())
        chk($sformatf("%s_%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
    end
    outq.delete();
    outt.delete();
    expq.delete();
  endtask

  initial begin
    // reset state, words already queued
    push_words(48'hA000_0000_0000, 4);
    eth_available = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd", 64'(fifo_read_enabled), 64'd0);
    chk("rst_valid", 64'(eth_data_valid), 64'd0);
    chk("rst_flush", 64'(eth_flush), 64'd0);
    chk("rst_data", 64'(eth_data), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_pop", 64'(fifo_read_enabled), 64'd0);

    // one full frame of 4
    wait_out(6, 200, "a_cnt");
    chk("a_trailer", 64'(outq[4]), 64'h0000_A5C3_0000_0400);
    add_frame(48'hA000_0000_0000, 4, 16'd0);
    cmp_all("a");
    chk("a_fc", 64'(frame_count), 64'd1);

    // 32 words with eth_available toggling every 3 cycles
    push_words(48'hB000_0000_0100, 32);
    fork
      begin
        while (!tog_stop) begin
          repeat (3) @(posedge clk);
          #1 eth_available = ~eth_available;
        end
      end
      begin
        wait_out(48, 4000, "b_cnt");
        tog_stop = 1'b1;
      end
    join
    eth_available = 1'b1;
    for (int f = 0; f < 8; f++)
      add_frame(48'hB000_0000_0100 + 48'(4 * f), 4, 16'(f + 1));
    cmp_all("b");
    chk("b_fc", 64'(frame_count), 64'd9);

    // sequence wrap
    @(negedge clk);
    force dut.seq = 16'hFFFF;
    @(negedge clk);
    release dut.seq;
    push_words(48'hC000_0000_0000, 4);
    wait_out(6, 200, "c_cnt");
    add_frame(48'hC000_0000_0000, 4, 16'hFFFF);
    cmp_all("c");
    chk("c_fc", 64'(frame_count), 64'd0);

    // partial frame followed by an empty FIFO
    push_words(48'hD000_0000_0000, 3);
`ifdef SAMPLE_FRAMER_TIMEOUT_EN
    wait_out(5, 400, "d_cnt");
    if (outt.size() == 5)
      chk("d_delay", 64'((outt[3] - outt[2]) >= 100 &&
                         (outt[3] - outt[2]) <= 110), 64'd1);
    add_frame(48'hD000_0000_0000, 3, 16'd0);
    cmp_all("d");
    chk("d_fc", 64'(frame_count), 64'd1);
`else
    repeat (10000) @(posedge clk);
    chk("d_cnt", 64'(outq.size()), 64'd3);
    chk("d_fc", 64'(frame_count), 64'd0);
    outq.delete();
    outt.delete();
`endif

    // reset while holding the third word of a frame
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    outq.delete();
    outt.delete();
    push_words(48'hE000_0000_0000, 2);
    wait_out(2, 200, "e_pre");
    outq.delete();
    outt.delete();
    @(posedge clk);
    #1 eth_available = 1'b0;
    push_words(48'hE000_0000_0002, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("e_held_data", 64'(eth_data), 64'hE000_0000_0001);
    #1 rst_n = 1'b0;
    #1;
    chk("e_rst_rd", 64'(fifo_read_enabled), 64'd0);
    chk("e_rst_valid", 64'(eth_data_valid), 64'd0);
    chk("e_rst_flush", 64'(eth_flush), 64'd0);
    chk("e_rst_data", 64'(eth_data), 64'd0);
    chk("e_rst_fc", 64'(frame_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    eth_available = 1'b1;
    push_words(48'hF000_0000_0000, 4);
    wait_out(6, 200, "e_cnt");
    add_frame(48'hF000_0000_0000, 4, 16'd0);
    cmp_all("e");
    chk("e_fc", 64'(frame_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
